// File: rtl/vga_pattern_pkg.sv
// Shared types, colour codes and helpers for the VGA test-pattern generator.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_GRID    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_t;

    // 3-bit colour codes, bit order {R,G,B}
    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    localparam int MAX_BPC = 8;

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = COLOR_WHITE;
            3'd1:    c = COLOR_YELLOW;
            3'd2:    c = COLOR_CYAN;
            3'd3:    c = COLOR_GREEN;
            3'd4:    c = COLOR_MAGENTA;
            3'd5:    c = COLOR_RED;
            3'd6:    c = COLOR_BLUE;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

    // Each set code bit fills its whole channel; callers truncate to 3*bpc.
    function automatic logic [3*MAX_BPC-1:0] expand_color(input logic [2:0] code, input int bpc);
        logic [3*MAX_BPC-1:0] v;
        v = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < MAX_BPC; i++) begin
                if (i < bpc) v[c*bpc+i] = code[c];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/box_bouncer.sv
// Bouncing-box position/direction state, stepped once per unpaused frame tick.
module box_bouncer #(
    parameter int H_VISIBLE = 256,
    parameter int V_VISIBLE = 240,
    parameter int CW        = 9,
    parameter int BOX_SIZE  = 16,
    parameter int SPEED     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          pause,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);
    localparam int CW2 = CW + 2;

    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinate

    // Returns {dir, pos}; the wall hit parks the box flush and reverses it.
    function automatic logic [CW:0] step_axis(input logic [CW-1:0] p, input logic dir, input int lim);
        logic [CW:0] r;
        if (dir && (CW2'(p) + CW2'(BOX_SIZE + SPEED) > CW2'(lim)))
            r = {1'b0, CW'(lim - BOX_SIZE)};
        else if (!dir && (p < CW'(SPEED)))
            r = {1'b1, {CW{1'b0}}};
        else if (dir)
            r = {1'b1, p + CW'(SPEED)};
        else
            r = {1'b0, p - CW'(SPEED)};
        return r;
    endfunction

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;
        if (tick && !pause) begin
            {dx_d, x_d} = step_axis(x_q, dx_q, H_VISIBLE);
            {dy_d, y_d} = step_axis(y_q, dy_q, V_VISIBLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source driven by hvsync_generator coordinates.
// Define PATTERN_BGR_EN to pack rgb as {B,G,R} for boards wired that way.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_VISIBLE = 256,
    parameter int V_VISIBLE = 240,
    parameter int CW        = 9,
    parameter int BPC       = 1,
    parameter int BOX_SIZE  = 16,
    parameter int SPEED     = 1,
    parameter int CHK_LOG2  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             display_on,
    input  logic [CW-1:0]    hc_visible,
    input  logic [CW-1:0]    vc_visible,
    input  logic             vsync,
    input  logic             mode_next,
    input  logic             pause,
    output logic [3*BPC-1:0] rgb,
    output logic [1:0]       mode,
    output logic [7:0]       frame_cnt
);
    localparam int            CW1    = CW + 1;
    localparam logic [CW-1:0] H_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_VISIBLE - 1);
    localparam logic [CW-1:0] BAR_W  = CW'(H_VISIBLE / 8);

    logic             vsync_q, mn_q, pending_q, pending_d;
    mode_t            mode_q, mode_d;
    logic [7:0]       fc_q, fc_d;
    logic [3*BPC-1:0] rgb_q, rgb_d;
    logic             tick, mn_rise;
    logic [CW-1:0]    box_x, box_y;
    logic [2:0]       code, out_code, bar_idx;
    logic             chk_on, in_box;

    assign tick    = vsync & ~vsync_q;
    assign mn_rise = mode_next & ~mn_q;

    box_bouncer #(
        .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE), .CW(CW),
        .BOX_SIZE(BOX_SIZE), .SPEED(SPEED)
    ) u_box (
        .clk(clk), .reset(reset), .tick(tick), .pause(pause),
        .x(box_x), .y(box_y)
    );

    // A press seen at the tick itself advances immediately; otherwise it waits.
    always_comb begin
        mode_d    = mode_q;
        pending_d = pending_q;
        fc_d      = fc_q;
        if (tick && (pending_q || mn_rise)) begin
            mode_d    = mode_t'(mode_q + 2'd1);
            pending_d = 1'b0;
        end else if (mn_rise) begin
            pending_d = 1'b1;
        end
        if (tick && !pause) fc_d = fc_q + 8'd1;
    end

    assign bar_idx = 3'(hc_visible / BAR_W);
    assign chk_on  = 1'((({1'b0, hc_visible} + CW1'(fc_q)) >> CHK_LOG2)) ^ vc_visible[CHK_LOG2];
    assign in_box  = ({1'b0, hc_visible} >= {1'b0, box_x}) &&
                     ({1'b0, hc_visible} <  {1'b0, box_x} + CW1'(BOX_SIZE)) &&
                     ({1'b0, vc_visible} >= {1'b0, box_y}) &&
                     ({1'b0, vc_visible} <  {1'b0, box_y} + CW1'(BOX_SIZE));

    always_comb begin
        code = COLOR_BLACK;
        if (display_on) begin
            case (mode_q)
                MODE_GRID: begin
                    if (hc_visible == '0 || hc_visible == H_LAST)      code = COLOR_RED;
                    else if (vc_visible == '0 || vc_visible == V_LAST) code = COLOR_YELLOW;
                    else if (hc_visible == vc_visible)                 code = COLOR_CYAN;
                    else if ({1'b0, hc_visible} + {1'b0, vc_visible} == CW1'(V_VISIBLE - 1))
                                                                       code = COLOR_MAGENTA;
                    else                                               code = COLOR_WHITE;
                end
                MODE_BARS:    code = bar_color(bar_idx);
                MODE_CHECKER: code = chk_on ? COLOR_WHITE : COLOR_BLACK;
                default:      code = in_box ? COLOR_GREEN : COLOR_BLUE;
            endcase
        end
    end

`ifdef PATTERN_BGR_EN
    assign out_code = {code[0], code[1], code[2]};
`else
    assign out_code = code;
`endif
    assign rgb_d = (3*BPC)'(expand_color(out_code, BPC));

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            mn_q      <= 1'b0;
            pending_q <= 1'b0;
            mode_q    <= MODE_GRID;
            fc_q      <= '0;
            rgb_q     <= '0;
        end else begin
            vsync_q   <= vsync;
            mn_q      <= mode_next;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            fc_q      <= fc_d;
            rgb_q     <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign mode      = mode_q;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed plus randomized check of vga_pattern_gen against a behavioural model.
module tb_vga_pattern_gen;
    localparam int H = 256, V = 240, CW = 9, BPC = 1, BS = 16, SP = 1, CL = 4;
    localparam logic [2:0] BLK = 3'b000, BLU = 3'b001, GRN = 3'b010, CYN = 3'b011,
                           RED = 3'b100, MAG = 3'b101, YEL = 3'b110, WHT = 3'b111;
    localparam logic [2:0] BAR_TBL [8] = '{WHT, YEL, CYN, GRN, MAG, RED, BLU, BLK};

    logic clk = 1'b0;
    logic reset = 1'b1, display_on = 1'b0, vsync = 1'b0, mode_next = 1'b0, pause = 1'b0;
    logic [CW-1:0] hc = '0, vc = '0;
    logic [3*BPC-1:0] rgb;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    vga_pattern_gen #(.H_VISIBLE(H), .V_VISIBLE(V), .CW(CW), .BPC(BPC),
                      .BOX_SIZE(BS), .SPEED(SP), .CHK_LOG2(CL)) dut (
        .clk(clk), .reset(reset), .display_on(display_on),
        .hc_visible(hc), .vc_visible(vc), .vsync(vsync),
        .mode_next(mode_next), .pause(pause),
        .rgb(rgb), .mode(mode), .frame_cnt(frame_cnt)
    );

    int n_assert = 0, n_fail = 0;
    int m_mode = 0, m_pend = 0, m_fc = 0, bx = 0, by = 0, dxp = 1, dyp = 1;
    bit m_vs = 0, m_mn = 0;
    logic [2:0] exp_rgb = '0;

    function automatic logic [2:0] fix(input logic [2:0] c);
`ifdef PATTERN_BGR_EN
        return {c[0], c[1], c[2]};
`else
        return c;
`endif
    endfunction

    function automatic logic [2:0] pix(input int md, input int h, input int v, input bit on,
                                       input int fc, input int x, input int y);
        if (!on) return BLK;
        case (md)
            0: begin
                if (h == 0 || h == H-1) return RED;
                if (v == 0 || v == V-1) return YEL;
                if (h == v) return CYN;
                if (h == V-1-v) return MAG;
                return WHT;
            end
            1: return BAR_TBL[h / (H/8)];
            2: return ((((h + fc) >> CL) & 1) ^ ((v >> CL) & 1)) != 0 ? WHT : BLK;
            default: return (h >= x && h < x+BS && v >= y && v < y+BS) ? GRN : BLU;
        endcase
    endfunction

    task automatic axis(inout int p, inout int dp, input int lim);
        if (dp == 1 && p + BS + SP > lim) begin p = lim - BS; dp = 0; end
        else if (dp == 0 && p < SP)       begin p = 0; dp = 1; end
        else if (dp == 1)                 p = p + SP;
        else                              p = p - SP;
    endtask

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic step();
        bit tk, ed;
        tk = vsync && !m_vs;
        ed = mode_next && !m_mn;
        exp_rgb = reset ? BLK : fix(pix(m_mode, int'(hc), int'(vc), display_on, m_fc, bx, by));
        if (reset) begin
            m_mode = 0; m_pend = 0; m_fc = 0; bx = 0; by = 0; dxp = 1; dyp = 1; m_vs = 0; m_mn = 0;
        end else begin
            if (tk && (m_pend == 1 || ed)) begin m_mode = (m_mode + 1) % 4; m_pend = 0; end
            else if (ed) m_pend = 1;
            if (tk && !pause) begin
                m_fc = (m_fc + 1) % 256;
                axis(bx, dxp, H);
                axis(by, dyp, V);
            end
            m_vs = vsync;
            m_mn = mode_next;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rgb"},  32'(rgb), 32'(exp_rgb));
        chk({tag, "_mode"}, 32'(mode), 32'(m_mode));
        chk({tag, "_fc"},   32'(frame_cnt), 32'(m_fc));
        chk({tag, "_x"},    32'(dut.u_box.x), 32'(bx));
        chk({tag, "_y"},    32'(dut.u_box.y), 32'(by));
    endtask

    task automatic frame();
        vsync = 1'b1; step();
        vsync = 1'b0; step();
    endtask

    initial begin
        int gh[5], gv[5];
        logic [2:0] gc[5];
        int px, py, sfc, sx, sy, smode;
        bit saw_x, saw_y;

        // 1: reset
        repeat (3) step();
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_fc", 32'(frame_cnt), 0);
        chk("rst_x", 32'(dut.u_box.x), 0);
        chk("rst_y", 32'(dut.u_box.y), 0);
        reset = 1'b0;

        // 2: grid colours
        gh = '{0, 50, 50, 50, 60};
        gv = '{50, 0, 50, 189, 70};
        gc = '{RED, YEL, CYN, MAG, WHT};
        display_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hc = CW'(gh[i]); vc = CW'(gv[i]);
            step();
            chk("grid_rgb", 32'(rgb), 32'(fix(gc[i])));
            chk("grid_model", 32'(rgb), 32'(exp_rgb));
        end
        display_on = 1'b0; step();
        chk("blank_rgb", 32'(rgb), 0);

        // 3: mode stepping
        mode_next = 1'b1; step(); mode_next = 1'b0; step();
        repeat (3) step();
        chk("pend_mode", 32'(mode), 0);
        vsync = 1'b1; step();
        chk("step1_mode", 32'(mode), 1);
        vsync = 1'b0; step();
        display_on = 1'b1; hc = 9'd96; vc = 9'd10; step();
        chk("bars96", 32'(rgb), 32'(fix(GRN)));
        hc = 9'd255; step();
        chk("bars255", 32'(rgb), 32'(fix(BLK)));
        for (int i = 0; i < 3; i++) begin
            mode_next = 1'b1; step(); mode_next = 1'b0; step();
        end
        chk("multi_pend", 32'(mode), 1);
        frame();
        chk("multi_step", 32'(mode), 2);
        frame();
        chk("no_extra", 32'(mode), 2);
        mode_next = 1'b1; vsync = 1'b1; step();
        chk("same_cycle", 32'(mode), 3);
        mode_next = 1'b0; vsync = 1'b0; step();
        chk_all("pre_box");

        // 4: bouncing box
        saw_x = 0; saw_y = 0;
        for (int t = 0; t < 300; t++) begin
            px = int'(dut.u_box.x); py = int'(dut.u_box.y);
            hc = CW'($urandom_range(0, H-1)); vc = CW'($urandom_range(0, V-1));
            frame();
            if (px == 240 && int'(dut.u_box.x) == 239) saw_x = 1;
            if (py == 224 && int'(dut.u_box.y) == 223) saw_y = 1;
            chk_all("box");
        end
        chk("x_bounce", 32'(saw_x), 1);
        chk("y_bounce", 32'(saw_y), 1);
        hc = CW'(bx); vc = CW'(by); step();
        chk("box_corner", 32'(rgb), 32'(fix(GRN)));

        // 5: pause
        sfc = m_fc; sx = bx; sy = by; smode = m_mode;
        pause = 1'b1;
        repeat (10) frame();
        chk("pause_fc", 32'(frame_cnt), 32'(sfc));
        chk("pause_x", 32'(dut.u_box.x), 32'(sx));
        chk("pause_y", 32'(dut.u_box.y), 32'(sy));
        mode_next = 1'b1; step(); mode_next = 1'b0;
        frame();
        chk("pause_mode", 32'(mode), 32'((smode + 1) % 4));
        pause = 1'b0;

        // 6: randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            display_on = ($urandom_range(0, 7) != 0);
            vsync      = ($urandom_range(0, 3) == 0);
            mode_next  = ($urandom_range(0, 5) == 0);
            pause      = ($urandom_range(0, 4) == 0);
            hc = CW'($urandom_range(0, H-1));
            vc = ($urandom_range(0, 3) == 0) ? hc[CW-1:0] % CW'(V) : CW'($urandom_range(0, V-1));
            step();
            chk_all("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
